// File: rtl/enc8to3_if.sv
// enc8to3_if: request/code bus for the sequential 8-to-3 encoder.
//
// Handshake: the encoder (slave) presents a code on y/last with valid=1 and
// holds y, valid and last stable until the consumer (master) samples
// valid & ready high on a rising edge; only that edge advances the output.
// ready may toggle freely and carries no meaning while valid=0.
// load captures i only while valid=0; it is ignored at any other time.
// state_dbg mirrors the encoder state register (0 = IDLE, 1 = EMIT).
interface enc8to3_if;
   logic [7:0] i;
   logic       load;
   logic [2:0] y;
   logic       valid;
   logic       ready;
   logic       last;
   logic       zero;
   logic       state_dbg;

   modport master (
      output i, load, ready,
      input  y, valid, last, zero, state_dbg
   );

   modport slave (
      input  i, load, ready,
      output y, valid, last, zero, state_dbg
   );
endinterface

// File: rtl/enc8to3_seq.sv
// enc8to3_seq: sequential 8-to-3 encoder. A captured request vector is
// replayed as a stream of 3-bit indices, one per valid/ready handshake.
// Optional feature macro: ENC_RR_EN selects round-robin order (search
// starts after the last emitted code); without it, the lowest set index
// goes first and no pointer register exists.
module enc8to3_seq (
   input  logic      clk,
   input  logic      rst,
   enc8to3_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pending_q, pending_d;
   logic [2:0] y_q, y_d;
   logic       last_q, last_d;
   logic       zero_q, zero_d;

   logic [2:0] start;
   logic [7:0] sel_src;
   logic [2:0] sel_idx;
   logic [7:0] sel_rest;

   // First set bit of v, scanning upward from start and wrapping 7 -> 0.
   function automatic logic [2:0] pick_idx(input logic [7:0] v, input logic [2:0] start_idx);
      logic [2:0] idx;
      logic       found;
      pick_idx = 3'd0;
      found    = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx = start_idx + 3'(k);
         if (!found && v[idx]) begin
            pick_idx = idx;
            found    = 1'b1;
         end
      end
   endfunction

`ifdef ENC_RR_EN
   logic [2:0] ptr_q, ptr_d;

   // Round-robin: begin the search just past the last emitted code.
   always_comb begin
      start = ptr_q + 3'd1;
   end

   // Pointer register; reset to 7 so the first vector starts at index 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 3'd7;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: always search from index 0.
   always_comb begin
      start = 3'd0;
   end
`endif

   // Selection datapath: idle picks from the incoming vector, emit from
   // the remaining pending bits.
   always_comb begin
      sel_src  = (state_q == IDLE) ? bus.i : pending_q;
      sel_idx  = pick_idx(sel_src, start);
      sel_rest = sel_src & ~(8'd1 << sel_idx);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      y_d       = y_q;
      last_d    = last_q;
      zero_d    = 1'b0;
`ifdef ENC_RR_EN
      ptr_d     = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.load) begin
               if (bus.i != 8'd0) begin
                  pending_d = sel_rest;
                  y_d       = sel_idx;
                  last_d    = (sel_rest == 8'd0);
                  state_d   = EMIT;
`ifdef ENC_RR_EN
                  ptr_d     = sel_idx;
`endif
               end else begin
                  zero_d = 1'b1;
               end
            end
         end
         EMIT: begin
            if (bus.ready) begin
               if (last_q) begin
                  // y keeps its final value; load is ignored on this edge.
                  last_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  pending_d = sel_rest;
                  y_d       = sel_idx;
                  last_d    = (sel_rest == 8'd0);
`ifdef ENC_RR_EN
                  ptr_d     = sel_idx;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= 8'd0;
         y_q       <= 3'd0;
         last_q    <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         y_q       <= y_d;
         last_q    <= last_d;
         zero_q    <= zero_d;
      end
   end

   // All outputs come straight from flops.
   always_comb begin
      bus.y         = y_q;
      bus.valid     = (state_q == EMIT);
      bus.last      = last_q;
      bus.zero      = zero_q;
      bus.state_dbg = state_q;
   end

endmodule

// File: tb/tb_enc8to3_seq.sv
// tb_enc8to3_seq: directed vector table plus hand-written multi-cycle
// sequences for the sequential 8-to-3 encoder.
module tb_enc8to3_seq;

   logic clk;
   logic rst;
   enc8to3_if bus ();

   enc8to3_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_pass;

   typedef struct {
      logic       rst;
      logic       load;
      logic [7:0] i;
      logic       ready;
      logic       e_valid;
      logic [2:0] e_y;
      logic       e_last;
      logic       e_zero;
   } vec_t;

   vec_t vecs[12];

   // Drive inputs, then let one rising edge pass; outputs are stable 1ns later.
   task automatic drive(input logic r, input logic ld, input logic [7:0] iv, input logic rdy);
      rst       = r;
      bus.load  = ld;
      bus.i     = iv;
      bus.ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Compare {valid, state_dbg, y, last, zero} against the expected values.
   task automatic check(input string name, input logic ev, input logic [2:0] ey,
                        input logic el, input logic ez);
      logic [6:0] act;
      logic [6:0] exp;
      act = {bus.valid, bus.state_dbg, bus.y, bus.last, bus.zero};
      exp = {ev, ev, ey, el, ez};
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got valid=%b st=%b y=%0d last=%b zero=%b, expected valid=%b st=%b y=%0d last=%b zero=%b",
                  name, act[6], act[5], act[4:2], act[1], act[0],
                  exp[6], exp[5], exp[4:2], exp[1], exp[0]);
      end
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   logic [2:0] rr_first;
   logic [2:0] rr_second;

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      bus.load  = 1'b0;
      bus.i     = 8'h00;
      bus.ready = 1'b0;

      //          rst   load  i      ready  valid y     last  zero
      vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}; // reset state
      vecs[1]  = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0}; // A4: first code 2
      vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0}; // last code
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0}; // valid falls, y held
      vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0, 1'b1}; // zero vector pulse
      vecs[6]  = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0}; // zero drops, single bit
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0}; // 06: codes 1, 2
      vecs[9]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0}; // load while busy ignored
      vecs[10] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0}; // ignored on final handshake
      vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0}; // no stray code 0

      for (int k = 0; k < 12; k++) begin
         drive(vecs[k].rst, vecs[k].load, vecs[k].i, vecs[k].ready);
         check($sformatf("vec%0d", k), vecs[k].e_valid, vecs[k].e_y, vecs[k].e_last, vecs[k].e_zero);
      end

      // Backpressure: 8'h81 with ready low for three cycles.
      do_reset();
      drive(1'b0, 1'b1, 8'h81, 1'b0);
      check("bp_first", 1'b1, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 8'h00, 1'b0);
         check($sformatf("bp_hold%0d", k), 1'b1, 3'd0, 1'b0, 1'b0);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("bp_second", 1'b1, 3'd7, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("bp_done", 1'b0, 3'd7, 1'b0, 1'b0);

      // Reset mid-burst: 8'hFF, reset after two handshakes.
      do_reset();
      drive(1'b0, 1'b1, 8'hFF, 1'b1);
      check("rmb_c0", 1'b1, 3'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("rmb_c1", 1'b1, 3'd1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("rmb_c2", 1'b1, 3'd2, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 8'h10, 1'b1);
      check("rmb_reset", 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 8'h00, 1'b1);
         check($sformatf("rmb_quiet%0d", k), 1'b0, 3'd0, 1'b0, 1'b0);
      end

      // Selection order across vectors: 8'h05 then 8'h12.
`ifdef ENC_RR_EN
      rr_first  = 3'd4;
      rr_second = 3'd1;
`else
      rr_first  = 3'd1;
      rr_second = 3'd4;
`endif
      do_reset();
      drive(1'b0, 1'b1, 8'h05, 1'b1);
      check("sel_a0", 1'b1, 3'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("sel_a1", 1'b1, 3'd2, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("sel_a_idle", 1'b0, 3'd2, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 8'h12, 1'b1);
      check("sel_b0", 1'b1, rr_first, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("sel_b1", 1'b1, rr_second, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("sel_b_idle", 1'b0, rr_second, 1'b0, 1'b0);

      // Final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
